// File: rtl/delay_line_prog.sv
// Programmable edge delay line: timestamped FIFO replay as modulated pulse bursts.
// Define LATE_DROP_EN to discard late FIFO heads instead of firing them late.
module delay_line_prog #(
    parameter int FIFO_DEPTH       = 1024,
    parameter int CTR_WIDTH        = 18,
    parameter int DELAY_RESET      = 92502,
    parameter int TIMEOUT_CYCLES   = 121,
    parameter int HALF_PERIOD_CLKS = 3,
    parameter int PULSE_WIDTH      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in,
    input  logic [CTR_WIDTH-1:0]   delay,
    input  logic                   delay_load,
    input  logic [PULSE_WIDTH-1:0] pulses,
    output logic                   out,
    output logic                   out_en,
    output logic                   busy,
    output logic                   overflow,
    output logic [15:0]            drop_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HC_W = $clog2(HALF_PERIOD_CLKS + 1);

    localparam logic [CTR_WIDTH-1:0] D_MIN = CTR_WIDTH'(8);
    localparam logic [CTR_WIDTH-1:0] D_MAX = {1'b0, {(CTR_WIDTH-1){1'b1}}};
    localparam logic [CTR_WIDTH-1:0] D_RST = CTR_WIDTH'(DELAY_RESET);
    localparam logic [CTR_WIDTH-1:0] D_ADJ = CTR_WIDTH'(4);
    localparam logic [TO_W-1:0]      TO_LD = TO_W'(TIMEOUT_CYCLES);
    localparam logic [HC_W-1:0]      H_LAST = HC_W'(HALF_PERIOD_CLKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    logic                   s1, s2, s3;
    logic                   ev_d, ev_q, ev_q2, in_flight;
    logic [TO_W-1:0]        to_cnt;
    logic [CTR_WIDTH-1:0]   ctr, delay_active, delay_clamped;
    logic [CTR_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]            wptr, rptr;
    logic                   fifo_empty, fifo_full;
    logic [CTR_WIDTH-1:0]   head, diff;
    logic                   due, late, pop, wr_ok, lost;
    logic                   trigger, late_drop;
    logic [1:0]             state;
    logic [HC_W-1:0]        hcnt;
    logic [PULSE_WIDTH-1:0] n, pulses_q;
    logic [1:0]             drop_inc;
    logic [16:0]            drop_sum;

    // Two sync flops, then s3 holds the previous synced value for rise detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ev_d      = s2 & ~s3 & (to_cnt == '0);
    assign in_flight = (s1 & ~s2) | (s2 & ~s3) | ev_q | ev_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            ev_q   <= 1'b0;
            ev_q2  <= 1'b0;
            ctr    <= '0;
        end else begin
            ev_q  <= ev_d;
            ev_q2 <= ev_q;
            ctr   <= ctr + CTR_WIDTH'(1);
            if (ev_d)
                to_cnt <= TO_LD;
            else if (to_cnt != '0)
                to_cnt <= to_cnt - TO_W'(1);
        end
    end

    always_comb begin
        delay_clamped = delay;
        if (delay < D_MIN)
            delay_clamped = D_MIN;
        else if (delay[CTR_WIDTH-1])
            delay_clamped = D_MAX;
    end

    always_ff @(posedge clk) begin
        if (reset)
            delay_active <= D_RST;
        else if (delay_load && !busy && !in_flight)
            delay_active <= delay_clamped;
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) &&
                        (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head = mem[rptr[AW-1:0]];
    // Modular difference keeps due/late ordering correct across counter wrap.
    assign diff = ctr - head;
    assign due  = (diff == '0);
    assign late = (diff != '0) && !diff[CTR_WIDTH-1];
    assign pop  = !fifo_empty && (state == S_IDLE) && (due || late);

`ifdef LATE_DROP_EN
    assign trigger   = pop & due;
    assign late_drop = pop & ~due;
`else
    assign trigger   = pop;
    assign late_drop = 1'b0;
`endif

    assign wr_ok = ev_q2 & (~fifo_full | pop);
    assign lost  = ev_q2 & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr[AW-1:0]] <= ctr + delay_active - D_ADJ;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + (AW+1)'(1);
            if (pop)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    assign drop_inc = {1'b0, lost} + {1'b0, late_drop};
    assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (lost)
                overflow <= 1'b1;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            out      <= 1'b0;
            out_en   <= 1'b0;
            hcnt     <= '0;
            n        <= '0;
            pulses_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (trigger) begin
                    state    <= S_HIGH;
                    out      <= 1'b1;
                    out_en   <= 1'b1;
                    hcnt     <= '0;
                    n        <= '0;
                    pulses_q <= (pulses == '0) ? PULSE_WIDTH'(1) : pulses;
                end
                S_HIGH: if (hcnt == H_LAST) begin
                    state <= S_LOW;
                    out   <= 1'b0;
                    hcnt  <= '0;
                end else begin
                    hcnt <= hcnt + HC_W'(1);
                end
                S_LOW: if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    if (n == pulses_q - PULSE_WIDTH'(1)) begin
                        state  <= S_IDLE;
                        out_en <= 1'b0;
                    end else begin
                        state <= S_HIGH;
                        out   <= 1'b1;
                        n     <= n + PULSE_WIDTH'(1);
                    end
                end else begin
                    hcnt <= hcnt + HC_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_delay_line_prog.sv
// Bench for delay_line_prog: directed and random edges against an event-level model.
// Model follows LATE_DROP_EN when the macro is defined for the build.
module tb_delay_line_prog;

    localparam int DEPTH = 4;
    localparam int CW    = 10;
    localparam int DRST  = 60;
    localparam int TO    = 8;
    localparam int HP    = 3;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in = 1'b0;
    logic [CW-1:0] delay = '0;
    logic          delay_load = 1'b0;
    logic [PW-1:0] pulses = '0;
    logic          out, out_en, busy, overflow;
    logic [15:0]   drop_count;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_line_prog #(
        .FIFO_DEPTH(DEPTH), .CTR_WIDTH(CW), .DELAY_RESET(DRST),
        .TIMEOUT_CYCLES(TO), .HALF_PERIOD_CLKS(HP), .PULSE_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset), .in(in), .delay(delay),
        .delay_load(delay_load), .pulses(pulses), .out(out),
        .out_en(out_en), .busy(busy), .overflow(overflow),
        .drop_count(drop_count)
    );

    // Observed bursts: rise edge, length, busy on the falling edge.
    int   act_rise[$];
    int   act_len[$];
    int   act_bf[$];
    int   cur_rise = 0;
    logic prev_en = 1'b0;
    int   wave_err = 0;

    always @(posedge clk) begin
        #1;
        if (out_en && !prev_en) begin
            act_rise.push_back(cyc);
            cur_rise = cyc;
        end
        if (!out_en && prev_en) begin
            act_len.push_back(cyc - cur_rise);
            act_bf.push_back(int'(busy));
        end
        if (out_en) begin
            if (out !== (((cyc - cur_rise) % (2*HP)) < HP)) wave_err++;
        end else if (out !== 1'b0) begin
            wave_err++;
        end
        prev_en = out_en;
    end

    // Event-level reference state (absolute edge numbers).
    int   last_acc, d_eff, burst_end, prev_pop, rst_edge;
    int   pops[$];
    int   exp_rise[$];
    int   exp_len[$];
    int   exp_drop;
    int   exp_ovf;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampd(input int v);
        if (v < 8) return 8;
        if (v >= (1 << (CW-1))) return (1 << (CW-1)) - 1;
        return v;
    endfunction

    // Pin edge sampled at edge t: accept, queue, or lose it; schedule its burst.
    task automatic model_event(input int t);
        int wt, occ, h, c0, p, st;
        if (t - last_acc <= TO) return;
        last_acc = t;
        wt = t + 4;
        occ = 0;
        foreach (pops[i]) if (pops[i] > wt) occ++;
        if (occ >= DEPTH) begin
            exp_ovf = 1;
            if (exp_drop < 65535) exp_drop++;
            return;
        end
        p = (pulses == 0) ? 1 : int'(pulses);
        h = t + d_eff - 1;
        c0 = wt;
        if (prev_pop > c0) c0 = prev_pop;
        if (burst_end > c0) c0 = burst_end;
        if (c0 <= h) begin
            st = h + 1;
        end else begin
`ifdef LATE_DROP_EN
            prev_pop = c0 + 1;
            pops.push_back(c0 + 1);
            if (exp_drop < 65535) exp_drop++;
            return;
`else
            st = c0 + 1;
`endif
        end
        exp_rise.push_back(st);
        exp_len.push_back(2*HP*p);
        burst_end = st + 2*HP*p;
        prev_pop = st;
        pops.push_back(st);
    endtask

    task automatic clear_q();
        act_rise.delete();
        act_len.delete();
        act_bf.delete();
        exp_rise.delete();
        exp_len.delete();
        wave_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in = 1'b0;
        delay_load = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rst_edge = cyc;
        last_acc = -1000;
        d_eff = DRST;
        burst_end = 0;
        prev_pop = 0;
        pops.delete();
        exp_drop = 0;
        exp_ovf = 0;
        clear_q();
    endtask

    task automatic fire();
        @(negedge clk);
        in = 1'b1;
        model_event(cyc + 1);
        repeat (2) @(negedge clk);
        in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int v);
        @(negedge clk);
        delay = CW'(v);
        delay_load = 1'b1;
        @(negedge clk);
        delay_load = 1'b0;
    endtask

    task automatic settle();
        int tgt;
        tgt = burst_end;
        if (prev_pop > tgt) tgt = prev_pop;
        if (last_acc + 12 > tgt) tgt = last_acc + 12;
        tgt += 4;
        while (cyc < tgt) @(negedge clk);
    endtask

    task automatic check_bursts(input string tag);
        chk({tag, "_count"}, act_rise.size(), exp_rise.size());
        for (int i = 0; i < exp_rise.size() && i < act_rise.size(); i++) begin
            chk({tag, "_rise"}, act_rise[i], exp_rise[i]);
            if (i < act_len.size())
                chk({tag, "_len"}, act_len[i], exp_len[i]);
        end
        chk({tag, "_wave"}, wave_err, 0);
        chk({tag, "_drop"}, int'(drop_count), exp_drop);
        chk({tag, "_ovf"}, int'(overflow), exp_ovf);
        chk({tag, "_busy"}, int'(busy), 0);
        clear_q();
    endtask

    initial begin
        int v, nf;
        do_reset();
        chk("rst_out", int'(out), 0);
        chk("rst_out_en", int'(out_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drop", int'(drop_count), 0);

        pulses = 2;
        idle(5);
        fire();
        settle();
        chk("basic_busy_fall", (act_bf.size() > 0) ? act_bf[0] : 1, 0);
        check_bursts("basic");

        fire();
        idle(2);
        fire();
        idle(17);
        fire();
        settle();
        check_bursts("debounce");

        load(20);
        d_eff = clampd(20);
        pulses = 15;
        fire();
        idle(7);
        fire();
        settle();
        check_bursts("late");

        load(5);
        d_eff = clampd(5);
        pulses = 1;
        fire();
        settle();
        check_bursts("clamp_lo");

        load(700);
        d_eff = clampd(700);
        fire();
        settle();
        check_bursts("clamp_hi");

        load(40);
        d_eff = clampd(40);
        pulses = 3;
        fire();
        while (exp_rise.size() > 0 && cyc < exp_rise[0] + 2) @(negedge clk);
        load(500);
        settle();
        fire();
        settle();
        check_bursts("load_busy");

        load(300);
        d_eff = clampd(300);
        pulses = 1;
        repeat (6) begin
            fire();
            idle(9);
        end
        settle();
        check_bursts("overflow");

        load(8);
        d_eff = clampd(8);
        while (((cyc + 2 - rst_edge) % (1 << CW)) != 1018) @(negedge clk);
        fire();
        settle();
        check_bursts("wrap");

        repeat (3) begin
            v = int'($urandom_range(0, 700));
            load(v);
            d_eff = clampd(v);
            pulses = PW'($urandom_range(0, 3));
            nf = int'($urandom_range(2, 6));
            repeat (nf) begin
                fire();
                idle(int'($urandom_range(0, 30)));
            end
            settle();
            check_bursts("rand");
        end

        load(30);
        d_eff = clampd(30);
        pulses = 3;
        fire();
        idle(3);
        fire();
        while (exp_rise.size() > 0 && cyc < exp_rise[0] + 4) @(negedge clk);
        do_reset();
        chk("midrst_out", int'(out), 0);
        chk("midrst_out_en", int'(out_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ovf", int'(overflow), 0);
        chk("midrst_drop", int'(drop_count), 0);
        idle(150);
        chk("midrst_lost", act_rise.size(), exp_rise.size());
        pulses = 2;
        fire();
        settle();
        check_bursts("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
